// File: rtl/bcd2bin11.sv
// bcd2bin11: sequential 4-digit BCD to 11-bit binary converter using reverse double-dabble.
module bcd2bin11 #(
  parameter int BIN_W = 11,
  parameter int N_DIG = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ones,
  input  logic [3:0]       tens,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       thousands,
  output logic [BIN_W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             digit_err
);
  localparam int BW = 4 * N_DIG;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [BW-1:0]    bcd_sr_q, bcd_sr_d, sh_bcd, cor_bcd, digits;
  logic [BIN_W-1:0] bin_sr_q, bin_sr_d, sh_bin, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             derr_q, derr_d, bad;
  logic             ovf_q, ovf_d, digit_err_q, digit_err_d, done_q, done_d;
  logic             last;
  assign digits = {thousands, hundreds, tens, ones};
  assign last   = cnt_q == CW'(BIN_W - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? SHIFT : IDLE) :
              state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // Shift the whole {bcd, bin} pair right, then pull each digit back into BCD range.
  always_comb begin
    {sh_bcd, sh_bin} = {bcd_sr_q, bin_sr_q} >> 1;
    cor_bcd = sh_bcd;
    bad = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      cor_bcd[4*i+:4] = sh_bcd[4*i+:4] >= 4'd8 ? sh_bcd[4*i+:4] - 4'd3 : sh_bcd[4*i+:4];
      bad = bad | (digits[4*i+:4] > 4'd9);
    end
  end
  always_comb begin
    bcd_sr_d    = bcd_sr_q;
    bin_sr_d    = bin_sr_q;
    cnt_d       = cnt_q;
    derr_d      = derr_q;
    b_d         = b_q;
    ovf_d       = ovf_q;
    digit_err_d = digit_err_q;
    done_d      = 1'b0;
    if (state_q == IDLE && start) begin
      bcd_sr_d = digits;
      bin_sr_d = '0;
      cnt_d    = '0;
      derr_d   = bad;
    end else if (state_q == SHIFT) begin
      bcd_sr_d = cor_bcd;
      bin_sr_d = sh_bin;
      cnt_d    = cnt_q + 1'b1;
      if (last) begin
        b_d         = derr_q ? '0 : sh_bin;
        ovf_d       = !derr_q && cor_bcd != '0;
        digit_err_d = derr_q;
        done_d      = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_sr_q    <= '0;
      bin_sr_q    <= '0;
      cnt_q       <= '0;
      derr_q      <= 1'b0;
      b_q         <= '0;
      ovf_q       <= 1'b0;
      digit_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bcd_sr_q    <= bcd_sr_d;
      bin_sr_q    <= bin_sr_d;
      cnt_q       <= cnt_d;
      derr_q      <= derr_d;
      b_q         <= b_d;
      ovf_q       <= ovf_d;
      digit_err_q <= digit_err_d;
      done_q      <= done_d;
    end
  end
  assign B         = b_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign digit_err = digit_err_q;
endmodule

// File: tb/tb_bcd2bin11.sv
// tb_bcd2bin11: randomized and directed checks of bcd2bin11 against a decimal model.
module tb_bcd2bin11;
  logic        clk = 0, reset = 1, start = 0;
  logic [3:0]  on = 0, te = 0, hu = 0, th = 0;
  logic [10:0] B;
  logic        busy, done, ovf, digit_err;
  int checks = 0, failures = 0;

  bcd2bin11 dut (.clk(clk), .reset(reset), .start(start), .ones(on), .tens(te),
                 .hundreds(hu), .thousands(th), .B(B), .busy(busy), .done(done),
                 .ovf(ovf), .digit_err(digit_err));

  always #5 clk = ~clk;

  task automatic model(input logic [3:0] a, b, c, d, output logic [10:0] eb,
                       output logic eo, output logic ee);
    int v;
    v  = a * 1000 + b * 100 + c * 10 + d;
    ee = a > 9 || b > 9 || c > 9 || d > 9;
    eb = ee ? 11'd0 : 11'(v % 2048);
    eo = !ee && v > 2047;
  endtask

  task automatic run(input logic [3:0] a, b, c, d, output int lat);
    th = a; hu = b; te = c; on = d; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1 lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    checks++;
    if (B !== 0 || busy !== 0 || done !== 0 || ovf !== 0 || digit_err !== 0) begin
      failures++;
      $display("FAIL reset_state B=%h busy=%b done=%b ovf=%b err=%b expected all 0", B, busy, done, ovf, digit_err);
    end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int lat, bc;
    th = 0; hu = 0; te = 0; on = 0; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 0; bc = 0;
    while (busy && bc < 30) begin
      if (done) lat = bc;
      bc++;
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 11) begin failures++; $display("FAIL zero_latency got %0d expected 11", lat); end
    checks++;
    if (bc !== 12) begin failures++; $display("FAIL zero_busy_cycles got %0d expected 12", bc); end
    checks++;
    if (B !== 0 || ovf !== 0 || digit_err !== 0) begin
      failures++; $display("FAIL zero_result B=%h ovf=%b err=%b expected 000/0/0", B, ovf, digit_err);
    end
  endtask

  task automatic test_directed;
    logic [3:0] tv[6][4] = '{'{2,0,4,7}, '{1,2,3,4}, '{2,0,4,8}, '{9,9,9,9}, '{0,0,4'hA,5}, '{0,0,1,0}};
    logic [10:0] eb; logic eo, ee; int lat;
    for (int i = 0; i < 6; i++) begin
      run(tv[i][0], tv[i][1], tv[i][2], tv[i][3], lat);
      model(tv[i][0], tv[i][1], tv[i][2], tv[i][3], eb, eo, ee);
      checks++;
      if (lat !== 11 || B !== eb || ovf !== eo || digit_err !== ee) begin
        failures++;
        $display("FAIL directed_%0d lat=%0d B=%h ovf=%b err=%b expected lat=11 B=%h ovf=%b err=%b",
                 i, lat, B, ovf, digit_err, eb, eo, ee);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t, d1, d2; logic [10:0] b1;
    th = 2; hu = 0; te = 4; on = 7; start = 1;
    @(posedge clk); #1 th = 1; hu = 2; te = 3; on = 4;
    t = 1; d1 = -1; d2 = -1; b1 = 0;
    while (d2 < 0 && t < 60) begin
      if (done && d1 < 0) begin d1 = t; b1 = B; end
      else if (done) d2 = t;
      @(posedge clk); #1 t++;
    end
    start = 0;
    checks++;
    if (b1 !== 11'h7FF) begin failures++; $display("FAIL b2b_first B=%h expected 7ff", b1); end
    checks++;
    if (d2 - d1 !== 13) begin failures++; $display("FAIL b2b_spacing got %0d expected 13", d2 - d1); end
    checks++;
    if (B !== 11'h4D2) begin failures++; $display("FAIL b2b_second B=%h expected 4d2", B); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, extra;
    th = 2; hu = 0; te = 4; on = 7; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    #1;
    checks++;
    if (B !== 0 || busy !== 0 || done !== 0) begin
      failures++; $display("FAIL reset_mid B=%h busy=%b done=%b expected 0/0/0", B, busy, done);
    end
    @(posedge clk); #1 reset = 0;
    extra = 0;
    repeat (20) begin @(posedge clk); #1 if (done) extra++; end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL reset_no_done got %0d pulses expected 0", extra); end
    run(1, 2, 3, 4, lat);
    checks++;
    if (lat !== 11 || B !== 11'h4D2) begin
      failures++; $display("FAIL reset_recover lat=%0d B=%h expected 11/4d2", lat, B);
    end
  endtask

  task automatic test_start_ignored;
    int lat, extra;
    th = 1; hu = 2; te = 3; on = 4; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 th = 9; hu = 8; te = 7; on = 6; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 4;
    while (!done && lat < 20) begin @(posedge clk); #1 lat++; end
    checks++;
    if (lat !== 11 || B !== 11'h4D2 || ovf !== 0) begin
      failures++; $display("FAIL start_ignored lat=%0d B=%h ovf=%b expected 11/4d2/0", lat, B, ovf);
    end
    extra = 0;
    repeat (20) begin @(posedge clk); #1 if (done) extra++; end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL start_ignored_extra got %0d expected 0", extra); end
  endtask

  task automatic test_random;
    logic [3:0] a, b, c, d; logic [10:0] eb; logic eo, ee; int lat, v;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(9) == 0) begin
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      end else begin
        v = i < 12 ? (i < 6 ? i : 9999 - i + 6) : $urandom_range(9999);
        if (i >= 6 && i < 12 && i % 2 == 0) v = 2045 + i - 6;
        a = 4'(v / 1000); b = 4'(v / 100 % 10); c = 4'(v / 10 % 10); d = 4'(v % 10);
      end
      run(a, b, c, d, lat);
      model(a, b, c, d, eb, eo, ee);
      checks++;
      if (lat !== 11 || B !== eb || ovf !== eo || digit_err !== ee) begin
        failures++;
        $display("FAIL random %h%h%h%h lat=%0d B=%h ovf=%b err=%b expected lat=11 B=%h ovf=%b err=%b",
                 a, b, c, d, lat, B, ovf, digit_err, eb, eo, ee);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_zero;
    test_directed;
    test_back_to_back;
    test_reset_mid;
    test_start_ignored;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
